// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter: shares the single RF write port between write-back (A) and a FIFO-buffered
// long-latency port (B). Build macro RF_ARB_ROUND_ROBIN_EN swaps the starvation guard for alternating grants.
module rf_wport_arbiter #(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_we,
  input  logic [4:0]  a_dest,
  input  logic [31:0] a_wdata,
  input  logic [31:0] a_pc,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_dest,
  input  logic [31:0] b_wdata,
  input  logic [31:0] b_pc,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] busy_mask,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(BUF_DEPTH);

  logic [4:0]       buf_dest  [BUF_DEPTH];
  logic [31:0]      buf_wdata [BUF_DEPTH];
  logic [31:0]      buf_pc    [BUF_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  logic        head_valid;
  logic        full;
  logic        push;
  logic        pop;
  logic        a_need;
  logic        grant_a;
  logic        grant_b;
  logic [31:0] out_pc;
  logic [31:0] busy_c;
  logic [BUF_DEPTH-1:0] slot_valid;

  assign head_valid = (count != '0);
  assign full       = (count == FULL_CNT);
  assign b_ready    = !full;
  assign push       = b_valid && !full;
  assign a_need     = a_valid && a_we && (a_dest != 5'd0);
  assign pop        = grant_b;

`ifdef RF_ARB_ROUND_ROBIN_EN
  // rr_b_turn=0 means A wins the next contended cycle; only contended cycles flip it.
  logic rr_b_turn;
  logic contended;

  assign contended = a_need && head_valid;
  assign grant_b   = head_valid && (!a_need || rr_b_turn);
  assign grant_a   = a_need && (!head_valid || !rr_b_turn);
  assign a_ready   = !(contended && rr_b_turn);

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_b_turn <= 1'b0;
    end else if (contended) begin
      rr_b_turn <= !rr_b_turn;
    end
  end
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;
  logic       force_b;

  assign force_b = head_valid && (starve_cnt == STARVE_MAX);
  assign a_ready = !force_b;
  assign grant_b = force_b || (head_valid && !a_need);
  assign grant_a = a_need && !force_b;

  always_ff @(posedge clk) begin
    if (reset || !head_valid || grant_b) begin
      starve_cnt <= 4'd0;
    end else if (grant_a && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_dest[wr_ptr]  <= b_dest;
      buf_wdata[wr_ptr] <= b_wdata;
      buf_pc[wr_ptr]    <= b_pc;
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar g = 0; g < BUF_DEPTH; g++) begin : g_slot
    logic [PTR_W-1:0] age;
    assign age           = PTR_W'(g) - rd_ptr;
    assign slot_valid[g] = ({1'b0, age} < count);
  end

  always_comb begin
    busy_c = '0;
    for (int s = 0; s < BUF_DEPTH; s++) begin
      if (slot_valid[s]) busy_c[buf_dest[s]] = 1'b1;
    end
    busy_c[0] = 1'b0;
  end

  assign busy_mask = busy_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= 32'd0;
      out_pc   <= 32'd0;
    end else if (grant_a) begin
      rf_we    <= 1'b1;
      rf_waddr <= a_dest;
      rf_wdata <= a_wdata;
      out_pc   <= a_pc;
    end else if (grant_b) begin
      rf_we    <= (buf_dest[rd_ptr] != 5'd0);
      rf_waddr <= buf_dest[rd_ptr];
      rf_wdata <= buf_wdata[rd_ptr];
      out_pc   <= buf_pc[rd_ptr];
    end else begin
      rf_we <= 1'b0;
    end
  end

  assign debug_wb_pc       = out_pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule
